// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between instruction fetch and the MEM stage.
// One transaction at a time over a req/ready/rvalid handshake; MEM-stage
// data requests outrank fetch so the older instruction completes first.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a per-transaction timeout
// that aborts a hung transaction, returns NOP/zero data and sets arb_err.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  output logic            if_stall,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_valid,
  output logic            d_stall,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            arb_err
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r,    state_nxt_s;
  logic            own_d_r,    own_d_nxt_s;
  logic            m_req_r,    m_req_nxt_s;
  logic            m_we_r,     m_we_nxt_s;
  logic [AW-1:0]   m_addr_r,   m_addr_nxt_s;
  logic [DW-1:0]   m_wdata_r,  m_wdata_nxt_s;
  logic [SW-1:0]   m_wstrb_r,  m_wstrb_nxt_s;
  logic            if_valid_r, if_valid_nxt_s;
  logic            d_valid_r,  d_valid_nxt_s;
  logic [DW-1:0]   if_rdata_r, if_rdata_nxt_s;
  logic [DW-1:0]   d_rdata_r,  d_rdata_nxt_s;
  logic            arb_err_r,  arb_err_nxt_s;
  logic            finish_s;
  logic            abort_s;
  logic [DW-1:0]   fin_data_s;
  logic            timeout_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [DW-1:0] NOP_WORD = DW'(32'h0000_0013);
  logic [7:0] tmo_cnt_r;

  // Timeout counter: zero outside a transaction, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  assign timeout_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                     (tmo_cnt_r == 8'(TIMEOUT));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic for the single-transaction sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    own_d_nxt_s    = own_d_r;
    m_req_nxt_s    = 1'b0;
    m_we_nxt_s     = m_we_r;
    m_addr_nxt_s   = m_addr_r;
    m_wdata_nxt_s  = m_wdata_r;
    m_wstrb_nxt_s  = m_wstrb_r;
    if_valid_nxt_s = 1'b0;
    d_valid_nxt_s  = 1'b0;
    if_rdata_nxt_s = if_rdata_r;
    d_rdata_nxt_s  = d_rdata_r;
    arb_err_nxt_s  = arb_err_r;
    finish_s       = 1'b0;
    abort_s        = 1'b0;
    fin_data_s     = m_rdata;

    case (state_r)
      ST_IDLE: begin
        if (d_read || d_write) begin
          // Data request wins: the MEM-stage instruction is older.
          state_nxt_s   = ST_REQ;
          own_d_nxt_s   = 1'b1;
          m_req_nxt_s   = 1'b1;
          m_we_nxt_s    = d_write;
          m_addr_nxt_s  = d_addr;
          m_wdata_nxt_s = d_wdata;
          m_wstrb_nxt_s = d_write ? d_wstrb : {SW{1'b0}};
        end else if (if_req) begin
          state_nxt_s   = ST_REQ;
          own_d_nxt_s   = 1'b0;
          m_req_nxt_s   = 1'b1;
          m_we_nxt_s    = 1'b0;
          m_addr_nxt_s  = if_addr;
          m_wdata_nxt_s = {DW{1'b0}};
          m_wstrb_nxt_s = {SW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_ready) begin
          state_nxt_s = ST_WAIT;
        end else if (timeout_s) begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
          abort_s     = 1'b1;
        end else begin
          m_req_nxt_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (m_rvalid) begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Requester still shows the finished request here, so never sample.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

`ifdef MEM_ARB_TIMEOUT_EN
    if (abort_s) begin
      fin_data_s    = own_d_r ? {DW{1'b0}} : NOP_WORD;
      arb_err_nxt_s = 1'b1;
    end else begin
      fin_data_s    = m_rdata;
    end
`else
    if (abort_s) begin
      fin_data_s = {DW{1'b0}};
    end else begin
      fin_data_s = m_rdata;
    end
`endif

    if (finish_s) begin
      if (own_d_r) begin
        d_valid_nxt_s = 1'b1;
        d_rdata_nxt_s = fin_data_s;
      end else begin
        if_valid_nxt_s = 1'b1;
        if_rdata_nxt_s = fin_data_s;
      end
    end else begin
      if_valid_nxt_s = 1'b0;
      d_valid_nxt_s  = 1'b0;
    end
  end

  // State and registered-output update; reset returns to IDLE with port quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      own_d_r    <= 1'b0;
      m_req_r    <= 1'b0;
      m_we_r     <= 1'b0;
      m_addr_r   <= {AW{1'b0}};
      m_wdata_r  <= {DW{1'b0}};
      m_wstrb_r  <= {SW{1'b0}};
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      if_rdata_r <= {DW{1'b0}};
      d_rdata_r  <= {DW{1'b0}};
      arb_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      own_d_r    <= own_d_nxt_s;
      m_req_r    <= m_req_nxt_s;
      m_we_r     <= m_we_nxt_s;
      m_addr_r   <= m_addr_nxt_s;
      m_wdata_r  <= m_wdata_nxt_s;
      m_wstrb_r  <= m_wstrb_nxt_s;
      if_valid_r <= if_valid_nxt_s;
      d_valid_r  <= d_valid_nxt_s;
      if_rdata_r <= if_rdata_nxt_s;
      d_rdata_r  <= d_rdata_nxt_s;
      arb_err_r  <= arb_err_nxt_s;
    end
  end

  assign m_req    = m_req_r;
  assign m_we     = m_we_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign m_wstrb  = m_wstrb_r;
  assign if_valid = if_valid_r;
  assign d_valid  = d_valid_r;
  assign if_rdata = if_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign arb_err  = arb_err_r;

  // Stalls are combinational so the freeze drops in the completion cycle.
  assign if_stall = if_req & ~if_valid_r;
  assign d_stall  = (d_read | d_write) & ~d_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// transactions against a transaction-level model (memory array + latency
// arithmetic). Timeout case is built only with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        d_valid, d_stall;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_ready, m_rvalid;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_if_rdata, exp_d_rdata;
  bit          d_known;
  logic        exp_arb;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] v;
    v = model_read(a);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) v[8*b +: 8] = w[8*b +: 8];
    end
    mem[a] = v;
  endtask

  task automatic check_reset_outs();
    check("rst_m_req", m_req, 1'b0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_wstrb", m_wstrb, 4'h0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_arb_err", arb_err, 1'b0);
  endtask

  task automatic check_steady(input bit exp_iv, input bit exp_dv);
    check("if_valid", if_valid, exp_iv);
    check("d_valid", d_valid, exp_dv);
    check("if_stall", if_stall, if_req & ~exp_iv);
    check("d_stall", d_stall, (d_read | d_write) & ~exp_dv);
    check("if_rdata", if_rdata, exp_if_rdata);
    if (d_known) check("d_rdata", d_rdata, exp_d_rdata);
    else checks++;
    check("arb_err", arb_err, exp_arb);
  endtask

  // One transaction starting in cycle 0 (DUT idle); rd/rv = extra wait cycles
  // of m_ready / m_rvalid. Completion expected in cycle 3+rd+rv.
  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int rd, input int rv);
    int          done_c;
    logic [31:0] rsp;
    bit          exp_req, exp_iv, exp_dv;
    done_c = 3 + rd + rv;
    rsp = (is_d && we) ? 32'($urandom) : model_read(addr);
    if (is_d) begin
      d_read = !we; d_write = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c <= done_c; c++) begin
      m_ready  = (c == 1 + rd);
      m_rvalid = (c >= 1 && c <= 1 + rd) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rdata  = $urandom;
      if (c == 2 + rd + rv) begin
        m_rvalid = 1'b1;
        m_rdata  = rsp;
      end
      exp_req = (c >= 1 && c <= 1 + rd);
      exp_iv  = (c == done_c) && !is_d;
      exp_dv  = (c == done_c) && is_d;
      if (c == done_c) begin
        if (!is_d) exp_if_rdata = rsp;
        else if (!we) begin exp_d_rdata = rsp; d_known = 1'b1; end
        else begin model_write(addr, wdata, wstrb); d_known = 1'b0; end
      end
      #1;
      check("m_req", m_req, exp_req);
      if (exp_req) begin
        check("m_addr", m_addr, addr);
        check("m_we", m_we, is_d & we);
        check("m_wstrb", m_wstrb, (is_d && we) ? wstrb : 4'h0);
        if (is_d && we) check("m_wdata", m_wdata, wdata);
      end
      check_steady(exp_iv, exp_dv);
      if (c == done_c) begin
        if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
        else if_req = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  // Fetch whose m_ready never comes: aborted with a NOP in cycle TMO+2.
  task automatic txn_timeout(input logic [31:0] addr);
    int done_c;
    bit exp_req, exp_iv;
    done_c = TMO + 2;
    if_req = 1'b1; if_addr = addr;
    for (int c = 0; c <= done_c; c++) begin
      m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
      exp_req = (c >= 1 && c <= TMO + 1);
      exp_iv  = (c == done_c);
      if (c == done_c) begin
        exp_if_rdata = 32'h0000_0013;
        exp_arb      = 1'b1;
      end
      #1;
      check("tmo_m_req", m_req, exp_req);
      check_steady(exp_iv, 1'b0);
      if (c == done_c) if_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    int          kind, rd, rv;
    bit          we;
    logic [31:0] a, fa, wd;
    logic [3:0]  ws;

    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; d_known = 1'b1; exp_arb = 1'b0;
    mem[32'h100] = 32'h0050_0093;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, zero-wait memory.
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0);
    check("fetch_word", exp_if_rdata, 32'h0050_0093);

    // Fetch and load together: data goes first, fetch follows in cycle 4.
    if_req = 1'b1; if_addr = 32'h104;
    txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 0, 0);
    txn(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 0);

    // Store with m_ready delayed two cycles, then read it back.
    txn(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 2, 0);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 2);
    check("store_merge", exp_d_rdata, (32'h40 ^ 32'h5A5A_0F0F) & 32'hFFFF_0000 | 32'h0000_BEEF);

`ifdef MEM_ARB_TIMEOUT_EN
    txn_timeout(32'h200);
    txn(1'b0, 1'b0, 32'h204, 32'h0, 4'h0, 1, 1);
`endif

    // Reset while in WAIT, then a stray late m_rvalid.
    d_read = 1'b1; d_addr = 32'h300;
    @(posedge clk); #1;
    m_ready = 1'b1;
    #1 check("pre_rst_m_req", m_req, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("wait_m_req", m_req, 1'b0);
    rst = 1'b0; d_read = 1'b0;
    #1;
    check_reset_outs();
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; d_known = 1'b1; exp_arb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      m_rvalid = (k == 0); m_rdata = 32'hBAD0_0000;
      #1;
      check("late_m_req", m_req, 1'b0);
      check_steady(1'b0, 1'b0);
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      rv   = $urandom_range(0, 3);
      a    = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      fa   = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      wd   = $urandom;
      ws   = 4'($urandom_range(1, 15));
      we   = 1'($urandom_range(0, 1));
      case (kind)
        0: txn(1'b0, 1'b0, a, 32'h0, 4'h0, rd, rv);
        1: txn(1'b1, 1'b0, a, 32'h0, 4'h0, rd, rv);
        2: txn(1'b1, 1'b1, a, wd, ws, rd, rv);
        default: begin
          if_req = 1'b1; if_addr = fa;
          txn(1'b1, we, a, wd, ws, rd, rv);
          txn(1'b0, 1'b0, fa, 32'h0, 4'h0, rv, rd);
        end
      endcase
    end

    // Quiet port afterwards.
    for (int k = 0; k < 3; k++) begin
      check("idle_m_req", m_req, 1'b0);
      check_steady(1'b0, 1'b0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch stage and the data-memory (MEM) stage of the pipelined core. It sequences one transaction at a time over a request/ready/response memory handshake and returns read data or a write acknowledgement to the winning stage. It raises per-requester stall signals that the hazard logic ORs into the pipeline freeze. Data requests from the MEM stage outrank fetch, so the older instruction always completes first.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (`DW/8` byte strobes)
- `TIMEOUT`, 255, cycles allowed per transaction before abort (used only with the macro; counter is 8 bits)

- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request, held stable until `if_valid`
- `if_addr` in AW: fetch address (PC)
- `if_rdata` out DW: instruction word, valid with `if_valid`
- `if_valid` out 1: one-cycle completion pulse for fetch
- `if_stall` out 1: `if_req & ~if_valid`
- `d_read` in 1: MemRead from the main decoder
- `d_write` in 1: MemWrite from the main decoder; `d_read` and `d_write` are never both high
- `d_addr` in AW: load/store address
- `d_wdata` in DW: store data
- `d_wstrb` in DW/8: store byte enables
- `d_rdata` out DW: load data, valid with `d_valid`
- `d_valid` out 1: one-cycle completion pulse for a load or store
- `d_stall` out 1: `(d_read|d_write) & ~d_valid`
- `m_req` out 1: memory request
- `m_we` out 1: write request
- `m_addr` out AW: memory address
- `m_wdata` out DW: memory write data
- `m_wstrb` out DW/8: memory byte enables (all zeros on reads)
- `m_ready` in 1: memory accepts the request this cycle
- `m_rvalid` in 1: response or write acknowledgement
- `m_rdata` in DW: memory read data
- `arb_err` out 1: sticky timeout flag

## Operation
- FSM has four states: IDLE, REQ, WAIT, DONE. Each register tracks the owner of the current transaction: `own_d` is 1 for data and 0 for fetch.
- IDLE:
  - If `d_read|d_write`, latch the data request and set `own_d=1`.
  - Else if `if_req`, latch the fetch request and set `own_d=0`.
  - Go to REQ when either request is present; otherwise stay in IDLE.
- REQ:
  - `m_req=1`, and the `m_*` outputs are driven from the latched registers.
  - On `m_ready`, go to WAIT.
- WAIT:
  - `m_req=0`.
  - On `m_rvalid`, capture `m_rdata` and go to DONE.
- DONE:
  - Pulse `if_valid` or `d_valid` according to `own_d`.
  - The rdata output holds the captured word until the next DONE.
  - Next state is IDLE unconditionally. DONE never samples requests, because the requester still shows the old request during this cycle.
- Store completion uses `m_rvalid` as the write acknowledgement, and `d_rdata` is don't-care for stores.
- `m_rvalid` is ignored outside WAIT; this is a protocol error and is not flagged.
- At most one outstanding transaction at a time.
- Both requesters pending in IDLE: data wins, and fetch stays stalled.
- Fetch cannot starve, because a data request exists only while the MEM stage holds it, and that stage advances after `d_valid`.

## Timing
- Reset values: FSM=IDLE, `m_req=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`, `m_wstrb=0`, `if_valid=0`, `d_valid=0`, `if_rdata=0`, `d_rdata=0`, `arb_err=0`. All outputs are registered except the stall signals.
- Latency with request sampled in IDLE at cycle 0, zero-wait memory (`m_ready` at cycle 1, `m_rvalid` at cycle 2):
  - `m_req` high in cycle 1
  - `m_rvalid` at the earliest in cycle 2
  - valid pulse in cycle 3
  - IDLE in cycle 4
- Minimum is 4 cycles per transaction; each wait cycle of `m_ready` or `m_rvalid` adds one.
- Back-to-back: the next request is sampled at cycle 4 at the earliest.
- Reset asserted mid-transaction: immediate return to IDLE with `m_req` low. A late `m_rvalid` after reset is ignored, and no valid pulse is produced.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and counts every cycle in REQ and WAIT.
  - On reaching `TIMEOUT`: force DONE, deassert `m_req`, and set `arb_err`.
  - Returned data: a fetch receives `32'h00000013` (NOP); a load receives 0.
  - `arb_err` stays set until reset.
- Undefined: no counter; REQ and WAIT wait indefinitely; `arb_err` is tied to 0.

## Test plan
- Fetch only, zero-wait memory, `if_addr=0x100`, `m_rdata=0x00500093` -> `m_req` in cycle 1 with `m_addr=0x100`, `m_we=0`; `if_valid` pulse in cycle 3 with `if_rdata=0x00500093`; `if_stall` high in cycles 0-2.
- `if_req` and `d_read` both set at cycle 0, `d_addr=0x2000` -> data issued first (`m_addr=0x2000`, `d_valid` in cycle 3); fetch issued next (`m_req` in cycle 5, `if_valid` in cycle 7).
- Store `d_addr=0x40`, `d_wdata=0xDEADBEEF`, `d_wstrb=4'b0011`, `m_ready` delayed 2 cycles -> `m_req` held cycles 1-3 with `m_we=1`, `m_wstrb=4'b0011`; `d_valid` one cycle after `m_rvalid`.
- `rst` pulled low while in WAIT, then `m_rvalid` arrives after reset is released -> all outputs 0, no `if_valid`/`d_valid`, FSM in IDLE.
- With `MEM_ARB_TIMEOUT_EN`, `m_ready` never asserts on a fetch -> `if_valid` with `if_rdata=0x00000013` once `TIMEOUT` is reached; `arb_err=1` stays set until reset; the next request proceeds normally.
